// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM encoding,
// the default access timeout and the store lane helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } lsu_state_t;

  localparam int unsigned LSU_TIMEOUT_CYCLES = 64;
  localparam int unsigned LSU_CNT_W          = 7;

  // Byte enables for an access of width f3 at byte offset off
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << off;
      F3_H, F3_HU: return 4'b0011 << off;
      default:     return 4'hF;
    endcase
  endfunction

  // Store data replicated across every lane the access could land on
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B, F3_BU: return {4{d[7:0]}};
      F3_H, F3_HU: return {2{d[15:0]}};
      default:     return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/grant/rvalid bus between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it by funct3.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs the dmem handshake, stalls the front of the pipe while an
// access is outstanding, aligns load data and forwards writeback controls to MEM/WB.
module mem_access_unit
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = LSU_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic        ex_mem_load,
  input  logic        ex_mem_store,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_result,
  input  logic [31:0] ex_mem_store_data,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_reg_file,
  mem_access_unit_if.master dmem,
  output logic        mem_stall,
  output logic        mem_wb_load,
  output logic        mem_wb_reg_file,
  output logic [31:0] mem_calculated_result,
  output logic [4:0]  mem_wb_rd,
  output logic [31:0] mem_read_data,
  output logic        mem_misaligned,
  output logic        mem_bus_err
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_REQ    = REQ;
  localparam logic [1:0] ST_WAIT_R = WAIT_R;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       offset_q, offset_d;

  logic        mem_op, misaligned, timeout;
  logic        req_c, stall_c, misal_c, bus_err_c, wb_ok;
  logic [31:0] load_data;

  assign mem_op  = ex_mem_valid & (ex_mem_load | ex_mem_store);
  assign timeout = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    case (ex_mem_funct3)
      F3_W:       misaligned = |ex_mem_result[1:0];
      F3_H, F3_HU: misaligned = ex_mem_result[0];
      default:    misaligned = 1'b0;
    endcase
  end

  // Lane offset is the one latched at grant, so a late address change cannot mis-steer the data
  lsu_load_align u_align (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (offset_q),
    .funct3_i (ex_mem_funct3),
    .data_o   (load_data)
  );

  // Next-state and handshake decode; a response in the timeout cycle wins over the abort
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    offset_d  = offset_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    misal_c   = 1'b0;
    bus_err_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && misaligned) begin
          misal_c = 1'b1;
        end else if (mem_op) begin
          req_c = 1'b1;
          cnt_d = '0;
          if (!dmem.dmem_gnt) begin
            state_d = ST_REQ;
            stall_c = 1'b1;
          end else if (!ex_mem_store) begin
            state_d  = ST_WAIT_R;
            offset_d = ex_mem_result[1:0];
            stall_c  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (dmem.dmem_gnt && ex_mem_store) begin
          state_d = ST_IDLE;
        end else if (dmem.dmem_gnt) begin
          state_d  = ST_WAIT_R;
          cnt_d    = '0;
          offset_d = ex_mem_result[1:0];
          stall_c  = 1'b1;
        end else if (timeout) begin
          state_d   = ST_IDLE;
          bus_err_c = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          stall_c = 1'b1;
        end
      end
      ST_WAIT_R: begin
        if (dmem.dmem_rvalid) begin
          state_d = ST_IDLE;
          rdata_d = load_data;
        end else if (timeout) begin
          state_d   = ST_IDLE;
          bus_err_c = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          stall_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      offset_q <= offset_d;
    end
  end

  // Every output, including the decoded ones, is forced low while reset is held
  assign wb_ok = rst & ex_mem_valid & ~stall_c & ~misal_c & ~bus_err_c;

  assign dmem.dmem_req   = rst & req_c;
  assign dmem.dmem_we    = rst & req_c & ex_mem_store;
  assign dmem.dmem_addr  = rst ? {ex_mem_result[31:2], 2'b00} : 32'h0;
  assign dmem.dmem_be    = rst ? lane_be(ex_mem_funct3, ex_mem_result[1:0]) : 4'h0;
  assign dmem.dmem_wdata = rst ? lane_wdata(ex_mem_funct3, ex_mem_store_data) : 32'h0;

  assign mem_stall             = rst & stall_c;
  assign mem_misaligned        = rst & misal_c;
  assign mem_bus_err           = rst & bus_err_c;
  assign mem_wb_load           = ex_mem_load & wb_ok;
  assign mem_wb_reg_file       = ex_mem_reg_file & wb_ok;
  assign mem_calculated_result = rst ? ex_mem_result : 32'h0;
  assign mem_wb_rd             = rst ? ex_mem_rd : 5'h0;
  assign mem_read_data         = rdata_q;

endmodule
